// File: rtl/imul_pipe.sv
// imul_pipe: fully pipelined RISC-V MUL/MULH/MULHU/MULHSU/MULW unit
// with global valid/ready stall, per-stage kill and resolve of speculation masks.
module imul_pipe #(
    parameter int XLEN   = 64,
    parameter int STAGES = 3,
    parameter int SPEC_W = 4,
    parameter int TAG_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              kill_en,
    input  logic [SPEC_W-1:0] kill_mask,
    input  logic              resolve_en,
    input  logic [SPEC_W-1:0] resolve_mask,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic              in_word,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic [SPEC_W-1:0] in_killmask,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int PW = 2 * XLEN + 2;

    function automatic logic [XLEN:0] ext(
        input logic [XLEN-1:0] x,
        input logic            sgn,
        input logic            w
    );
        if (w)
            return (XLEN+1)'($signed(x[31:0]));
        return {sgn & x[XLEN-1], x};
    endfunction

    // Both operands are widened to PW so a plain product is exact mod 2^PW.
    function automatic logic [XLEN-1:0] mul_sel(
        input logic [XLEN:0] a,
        input logic [XLEN:0] b,
        input logic          w,
        input logic          hi
    );
        logic [PW-1:0] p;
        p = {{(XLEN+1){a[XLEN]}}, a} * {{(XLEN+1){b[XLEN]}}, b};
        if (hi)
            return XLEN'(p >> XLEN);
        if (w)
            return XLEN'($signed(p[31:0]));
        return XLEN'(p);
    endfunction

    logic adv;
    logic in_w;
    logic in_hi;
    logic [XLEN:0] ea;
    logic [XLEN:0] eb;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign in_w     = in_word & (in_op == 2'b00);
    assign in_hi    = |in_op;
    assign ea       = ext(in_a, in_op != 2'b10, in_w);
    assign eb       = ext(in_b, ~in_op[1], in_w);

    logic              v_q [1:STAGES];
    logic [SPEC_W-1:0] m_q [1:STAGES];
    logic [TAG_W-1:0]  t_q [1:STAGES];

    // Index 0 is the entering uop; kill/resolve apply uniformly to all slots.
    logic              v_k [0:STAGES];
    logic [SPEC_W-1:0] m_s [0:STAGES];
    logic [SPEC_W-1:0] m_r [0:STAGES];
    logic              v_s [0:STAGES];
    logic [TAG_W-1:0]  t_s [0:STAGES-1];

    always_comb begin
        v_s[0] = in_valid;
        m_s[0] = in_killmask;
        t_s[0] = in_tag;
        for (int i = 1; i <= STAGES; i++) begin
            v_s[i] = v_q[i];
            m_s[i] = m_q[i];
        end
        for (int i = 1; i < STAGES; i++)
            t_s[i] = t_q[i];
        for (int i = 0; i <= STAGES; i++) begin
            v_k[i] = v_s[i] & ~(kill_en & |(m_s[i] & kill_mask));
            m_r[i] = resolve_en ? (m_s[i] & ~resolve_mask) : m_s[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i <= STAGES; i++) begin
            if (rst || flush)
                v_q[i] <= 1'b0;
            else
                v_q[i] <= adv ? v_k[i-1] : v_k[i];
            m_q[i] <= adv ? m_r[i-1] : m_r[i];
            if (adv)
                t_q[i] <= t_s[i-1];
        end
    end

    generate
        if (STAGES == 1) begin : g_one
            logic [XLEN-1:0] r_q;
            always_ff @(posedge clk) begin
                if (adv)
                    r_q <= mul_sel(ea, eb, in_w, in_hi);
            end
            assign out_result = r_q;
        end else begin : g_multi
            logic [XLEN:0]   a1;
            logic [XLEN:0]   b1;
            logic            w1;
            logic            hi1;
            logic [XLEN-1:0] r_q [2:STAGES];
            // Operands registered first; later stages give retiming room.
            always_ff @(posedge clk) begin
                if (adv) begin
                    a1     <= ea;
                    b1     <= eb;
                    w1     <= in_w;
                    hi1    <= in_hi;
                    r_q[2] <= mul_sel(a1, b1, w1, hi1);
                    for (int i = 3; i <= STAGES; i++)
                        r_q[i] <= r_q[i-1];
                end
            end
            assign out_result = r_q[STAGES];
        end
    endgenerate

    assign out_valid = v_q[STAGES];
    assign out_tag   = t_q[STAGES];

endmodule
